// File: rtl/gbtx_daq_pkg.sv
// Shared widths, idle encoding and FSM states for the GBTx DAQ packet arbiter.
package gbtx_daq_pkg;
    localparam int DAQ_W      = 18;
    localparam int DAQ_WORD_W = 19;
    localparam logic [DAQ_WORD_W-1:0] IDLE_WORD = 19'h40000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/gbtx_daq_arb_rr.sv
// Round-robin picker: combinational one-hot grant, pointer advances past the winner on upd_i.
// Zero latency from req_i to gnt_o; no backpressure of its own.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         upd_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr_q, ptr_d;
    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic           found;
    int             off, pos, nxt;

    // Rotate requests so bit 0 is the first candidate, then map the winner back.
    always_comb begin
        req2  = {req_i, req_i} >> ptr_q;
        rot   = req2[N-1:0];
        found = 1'b0;
        off   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                off   = k;
                found = 1'b1;
            end
        end
        pos = int'(ptr_q) + off;
        if (pos >= N) pos = pos - N;
        nxt   = (pos + 1 == N) ? 0 : pos + 1;
        gnt_o = found ? (N'(1) << pos) : '0;
        ptr_d = PW'(nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr_q <= '0;
        else if (upd_i) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/gbtx_daq_arb.sv
// Packet-atomic round-robin arbiter into the GBTx daq_word; words appear 1 cycle after transfer.
// Only the granted source sees ready; new grants wait for enable and synchronised tx-ready.
module gbtx_daq_arb
    import gbtx_daq_pkg::*;
#(
    parameter int N_SRC   = 2,
    parameter int MAX_PKT = 512,
    parameter int GAP_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_valid,
    input  logic [DAQ_W*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]       src_last,
    output logic [N_SRC-1:0]       src_ready,
    input  logic                   gbt_txrdy,
    input  logic                   enable,
    output logic [DAQ_WORD_W-1:0]  daq_word,
    output logic [N_SRC-1:0]       grant,
    output logic                   busy,
    output logic                   trunc_err,
    output logic [15:0]            pkt_cnt
);
    localparam int CW = $clog2(MAX_PKT + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q;
    logic                    txrdy_s;
    logic [N_SRC-1:0]        grant_q, grant_d, rr_gnt;
    logic [CW-1:0]           wcnt_q, wcnt_d;
    logic [GW-1:0]           gcnt_q, gcnt_d;
    logic [DAQ_WORD_W-1:0]   daq_q, daq_d;
    logic [15:0]             pkt_q, pkt_d;
    logic                    trunc_q, trunc_d;
    logic [DAQ_W-1:0]        sel_dat;
    logic                    sel_vld, sel_last, xfer, arb_go;

    assign txrdy_s = sync_q[1];
    assign arb_go  = (state_q == IDLE) && enable && txrdy_s && (|src_valid);

    rr_arbiter #(.N(N_SRC)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (src_valid),
        .upd_i (arb_go),
        .gnt_o (rr_gnt)
    );

    always_comb begin
        sel_dat  = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) begin
                sel_dat  = src_data[DAQ_W*i +: DAQ_W];
                sel_vld  = src_valid[i];
                sel_last = src_last[i];
            end
        end
    end

    assign xfer      = (state_q == SEND) && sel_vld;
    assign src_ready = (state_q == SEND) ? grant_q : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        daq_d   = IDLE_WORD;
        pkt_d   = pkt_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    grant_d = rr_gnt;
                    wcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    daq_d  = {1'b0, sel_dat};
                    wcnt_d = wcnt_q + 1'b1;
                    // The MAX_PKT-th word closes the packet even without last.
                    if (sel_last || (wcnt_q == CW'(MAX_PKT - 1))) begin
                        grant_d = '0;
                        pkt_d   = pkt_q + 16'd1;
                        gcnt_d  = '0;
                        if (!sel_last) trunc_d = 1'b1;
                        state_d = (GAP_CYC > 0) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                if (gcnt_q == GW'(GAP_CYC - 1)) state_d = IDLE;
                else                            gcnt_d  = gcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b00;
            grant_q <= '0;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            daq_q   <= IDLE_WORD;
            pkt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], gbt_txrdy};
            grant_q <= grant_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            daq_q   <= daq_d;
            pkt_q   <= pkt_d;
            trunc_q <= trunc_d;
        end
    end

    assign daq_word  = daq_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign trunc_err = trunc_q;
    assign pkt_cnt   = pkt_q;
endmodule
